hwpe_kernel_adapter_mc: RTL and testbench

Parametrised, multi-channel HWPE kernel adapter between streamer and accelerated kernel. Forwards N_IN input and N_OUT output valid/ready/data streams unchanged while counting transfers per channel against run-time programmed lengths. From those counts it derives sticky per-channel completion, a registered per-output element pulse, a job-level done pulse and an idle flag for the engine FSM. It replaces fixed "one token = ready" counting with programmable token counts and an explicit job state machine.

---
 rtl/hwpe_kernel_adapter_mc.sv | 149 ++++++++++++++
 tb/tb_hwpe_kernel_adapter_mc.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_kernel_adapter_mc.sv
// Multi-channel HWPE kernel adapter: pass-through streams with per-channel token counting and job FSM.
// Define HWPE_KA_INPUT_GATE_EN to block input channels outside RUN and once their count is complete.
module hwpe_kernel_adapter_mc #(
    parameter int unsigned N_IN   = 2,
    parameter int unsigned N_OUT  = 1,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     start_i,
    input  logic [N_IN*CNT_W-1:0]    max_in_i,
    input  logic [N_OUT*CNT_W-1:0]   max_out_i,
    input  logic [N_IN-1:0]          s_valid_i,
    output logic [N_IN-1:0]          s_ready_o,
    input  logic [N_IN*DATA_W-1:0]   s_data_i,
    output logic [N_IN-1:0]          k_valid_o,
    input  logic [N_IN-1:0]          k_ready_i,
    output logic [N_IN*DATA_W-1:0]   k_data_o,
    input  logic [N_OUT-1:0]         kr_valid_i,
    output logic [N_OUT-1:0]         kr_ready_o,
    input  logic [N_OUT*DATA_W-1:0]  kr_data_i,
    output logic [N_OUT-1:0]         m_valid_o,
    input  logic [N_OUT-1:0]         m_ready_i,
    output logic [N_OUT*DATA_W-1:0]  m_data_o,
    output logic [N_IN-1:0]          in_done_o,
    output logic [N_OUT-1:0]         out_pulse_o,
    output logic                     ready_o,
    output logic                     done_o,
    output logic                     idle_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]             state_q, state_d;
    logic [N_IN*CNT_W-1:0]  max_in_q, max_in_d, cnt_in_q, cnt_in_d;
    logic [N_OUT*CNT_W-1:0] max_out_q, max_out_d, cnt_out_q, cnt_out_d;
    logic [N_IN-1:0]        in_done_q, in_done_d;
    logic [N_OUT-1:0]       out_done_q, out_done_d;
    logic [N_OUT-1:0]       out_pulse_q, out_pulse_d;
    logic [N_IN-1:0]        gate_open, in_hs;
    logic [N_OUT-1:0]       out_hs;

    assign k_data_o   = s_data_i;
    assign m_data_o   = kr_data_i;
    assign kr_ready_o = m_ready_i;
    assign m_valid_o  = kr_valid_i;

`ifdef HWPE_KA_INPUT_GATE_EN
    assign gate_open = (state_q == ST_RUN) ? ~in_done_q : '0;
`else
    assign gate_open = '1;
`endif

    assign s_ready_o = k_ready_i & gate_open;
    assign k_valid_o = s_valid_i & gate_open;
    assign in_hs     = k_valid_o & k_ready_i;
    assign out_hs    = kr_valid_i & m_ready_i;

    assign in_done_o   = in_done_q;
    assign out_pulse_o = out_pulse_q;
    assign ready_o     = &in_done_q;
    assign done_o      = (state_q == ST_DONE);
    assign idle_o      = (state_q == ST_IDLE);

    always_comb begin
        state_d     = state_q;
        max_in_d    = max_in_q;
        max_out_d   = max_out_q;
        cnt_in_d    = cnt_in_q;
        cnt_out_d   = cnt_out_q;
        in_done_d   = in_done_q;
        out_done_d  = out_done_q;
        out_pulse_d = '0;
        if (clear_i) begin
            state_d    = ST_IDLE;
            cnt_in_d   = '0;
            cnt_out_d  = '0;
            in_done_d  = '0;
            out_done_d = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    state_d = ST_IDLE;
                    if (start_i) begin
                        max_in_d  = max_in_i;
                        max_out_d = max_out_i;
                        cnt_in_d  = '0;
                        cnt_out_d = '0;
                        // Zero-length channels count as complete from the start.
                        for (int i = 0; i < N_IN; i++)
                            in_done_d[i] = (max_in_i[i*CNT_W +: CNT_W] == '0);
                        for (int j = 0; j < N_OUT; j++)
                            out_done_d[j] = (max_out_i[j*CNT_W +: CNT_W] == '0);
                        state_d = (&out_done_d) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Counters stop at their programmed length, so surplus tokens are ignored.
                    for (int i = 0; i < N_IN; i++) begin
                        if (in_hs[i] && (cnt_in_q[i*CNT_W +: CNT_W] != max_in_q[i*CNT_W +: CNT_W]))
                            cnt_in_d[i*CNT_W +: CNT_W] = cnt_in_q[i*CNT_W +: CNT_W] + CNT_ONE;
                        in_done_d[i] = in_done_q[i] |
                                       (cnt_in_d[i*CNT_W +: CNT_W] == max_in_q[i*CNT_W +: CNT_W]);
                    end
                    for (int j = 0; j < N_OUT; j++) begin
                        if (out_hs[j] && (cnt_out_q[j*CNT_W +: CNT_W] != max_out_q[j*CNT_W +: CNT_W])) begin
                            cnt_out_d[j*CNT_W +: CNT_W] = cnt_out_q[j*CNT_W +: CNT_W] + CNT_ONE;
                            out_pulse_d[j] = 1'b1;
                        end
                        out_done_d[j] = out_done_q[j] |
                                        (cnt_out_d[j*CNT_W +: CNT_W] == max_out_q[j*CNT_W +: CNT_W]);
                    end
                    if (&out_done_d)
                        state_d = ST_DONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            max_in_q    <= '0;
            max_out_q   <= '0;
            cnt_in_q    <= '0;
            cnt_out_q   <= '0;
            in_done_q   <= '0;
            out_done_q  <= '0;
            out_pulse_q <= '0;
        end else begin
            state_q     <= state_d;
            max_in_q    <= max_in_d;
            max_out_q   <= max_out_d;
            cnt_in_q    <= cnt_in_d;
            cnt_out_q   <= cnt_out_d;
            in_done_q   <= in_done_d;
            out_done_q  <= out_done_d;
            out_pulse_q <= out_pulse_d;
        end
    end

endmodule

// File: tb/tb_hwpe_kernel_adapter_mc.sv
// Directed self-checking bench for hwpe_kernel_adapter_mc (N_IN=2, N_OUT=1).
// Expected values are hand-derived; gate-dependent expectations follow HWPE_KA_INPUT_GATE_EN.
module tb_hwpe_kernel_adapter_mc;

    localparam int N_IN   = 2;
    localparam int N_OUT  = 1;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

`ifdef HWPE_KA_INPUT_GATE_EN
    localparam int EXP_ACCEPTED = 2;
    localparam logic EXP_SREADY_AFTER = 1'b0;
`else
    localparam int EXP_ACCEPTED = 5;
    localparam logic EXP_SREADY_AFTER = 1'b1;
`endif

    logic                    clk_i = 1'b0;
    logic                    rst_ni;
    logic                    clear_i;
    logic                    start_i;
    logic [N_IN*CNT_W-1:0]   max_in_i;
    logic [N_OUT*CNT_W-1:0]  max_out_i;
    logic [N_IN-1:0]         s_valid_i;
    logic [N_IN-1:0]         s_ready_o;
    logic [N_IN*DATA_W-1:0]  s_data_i;
    logic [N_IN-1:0]         k_valid_o;
    logic [N_IN-1:0]         k_ready_i;
    logic [N_IN*DATA_W-1:0]  k_data_o;
    logic [N_OUT-1:0]        kr_valid_i;
    logic [N_OUT-1:0]        kr_ready_o;
    logic [N_OUT*DATA_W-1:0] kr_data_i;
    logic [N_OUT-1:0]        m_valid_o;
    logic [N_OUT-1:0]        m_ready_i;
    logic [N_OUT*DATA_W-1:0] m_data_o;
    logic [N_IN-1:0]         in_done_o;
    logic [N_OUT-1:0]        out_pulse_o;
    logic                    ready_o;
    logic                    done_o;
    logic                    idle_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk_i = ~clk_i;

    hwpe_kernel_adapter_mc #(
        .N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DATA_W), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
        .max_in_i(max_in_i), .max_out_i(max_out_i),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
        .k_valid_o(k_valid_o), .k_ready_i(k_ready_i), .k_data_o(k_data_o),
        .kr_valid_i(kr_valid_i), .kr_ready_o(kr_ready_o), .kr_data_i(kr_data_i),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
        .in_done_o(in_done_o), .out_pulse_o(out_pulse_o), .ready_o(ready_o),
        .done_o(done_o), .idle_o(idle_o)
    );

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        clear_i    = 1'b0;
        start_i    = 1'b0;
        s_valid_i  = '0;
        k_ready_i  = '0;
        kr_valid_i = '0;
        m_ready_i  = '0;
    endtask

    task automatic test_reset();
        rst_ni    = 1'b0;
        max_in_i  = '0;
        max_out_i = '0;
        s_data_i  = '0;
        kr_data_i = '0;
        idle_inputs();
        repeat (2) @(posedge clk_i);
        #1;
        total_cnt++; if (idle_o !== 1'b1) $display("[TB] FAIL reset_idle: got %0b expected 1", idle_o); else pass_cnt++;
        total_cnt++; if (done_o !== 1'b0) $display("[TB] FAIL reset_done: got %0b expected 0", done_o); else pass_cnt++;
        total_cnt++; if (in_done_o !== 2'b00) $display("[TB] FAIL reset_in_done: got %0b expected 00", in_done_o); else pass_cnt++;
        total_cnt++; if (ready_o !== 1'b0) $display("[TB] FAIL reset_ready: got %0b expected 0", ready_o); else pass_cnt++;
        total_cnt++; if (out_pulse_o !== 1'b0) $display("[TB] FAIL reset_pulse: got %0b expected 0", out_pulse_o); else pass_cnt++;
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_basic_job();
        max_in_i  = {16'd4, 16'd4};
        max_out_i = 16'd1;
        start_i   = 1'b1;
        step();
        start_i = 1'b0;
        total_cnt++; if (idle_o !== 1'b0) $display("[TB] FAIL basic_run_idle: got %0b expected 0", idle_o); else pass_cnt++;
        s_data_i  = {32'hBBBB_0001, 32'hAAAA_0001};
        s_valid_i = 2'b11;
        k_ready_i = 2'b11;
        kr_data_i = 32'hC0DE_1234;
        m_ready_i = 1'b0;
        #1;
        total_cnt++; if (k_data_o !== 64'hBBBB_0001_AAAA_0001) $display("[TB] FAIL basic_kdata: got %0h expected bbbb0001aaaa0001", k_data_o); else pass_cnt++;
        total_cnt++; if (m_data_o !== 32'hC0DE_1234) $display("[TB] FAIL basic_mdata: got %0h expected c0de1234", m_data_o); else pass_cnt++;
        total_cnt++; if (k_valid_o !== 2'b11 || s_ready_o !== 2'b11) $display("[TB] FAIL basic_handshake_fwd: got kv=%0b sr=%0b expected 11/11", k_valid_o, s_ready_o); else pass_cnt++;
        repeat (3) step();
        total_cnt++; if (in_done_o !== 2'b00) $display("[TB] FAIL basic_in_done_early: got %0b expected 00", in_done_o); else pass_cnt++;
        step();
        s_valid_i = '0;
        total_cnt++; if (in_done_o !== 2'b11) $display("[TB] FAIL basic_in_done: got %0b expected 11", in_done_o); else pass_cnt++;
        total_cnt++; if (ready_o !== 1'b1) $display("[TB] FAIL basic_ready: got %0b expected 1", ready_o); else pass_cnt++;
        total_cnt++; if (done_o !== 1'b0) $display("[TB] FAIL basic_done_early: got %0b expected 0", done_o); else pass_cnt++;
        kr_valid_i = 1'b1;
        m_ready_i  = 1'b1;
        #1;
        total_cnt++; if (kr_ready_o !== 1'b1 || m_valid_o !== 1'b1) $display("[TB] FAIL basic_out_fwd: got krr=%0b mv=%0b expected 1/1", kr_ready_o, m_valid_o); else pass_cnt++;
        step();
        kr_valid_i = 1'b0;
        m_ready_i  = 1'b0;
        total_cnt++; if (done_o !== 1'b1) $display("[TB] FAIL basic_done: got %0b expected 1", done_o); else pass_cnt++;
        total_cnt++; if (out_pulse_o !== 1'b1) $display("[TB] FAIL basic_pulse: got %0b expected 1", out_pulse_o); else pass_cnt++;
        total_cnt++; if (idle_o !== 1'b0) $display("[TB] FAIL basic_idle_in_done: got %0b expected 0", idle_o); else pass_cnt++;
        step();
        total_cnt++; if (done_o !== 1'b0 || idle_o !== 1'b1) $display("[TB] FAIL basic_after_done: got done=%0b idle=%0b expected 0/1", done_o, idle_o); else pass_cnt++;
    endtask

    task automatic test_out_toggle();
        int pulses;
        int dones;
        pulses = 0;
        dones  = 0;
        max_in_i  = {16'd0, 16'd0};
        max_out_i = 16'd3;
        start_i   = 1'b1;
        step();
        start_i = 1'b0;
        total_cnt++; if (in_done_o !== 2'b11) $display("[TB] FAIL toggle_zero_in: got %0b expected 11", in_done_o); else pass_cnt++;
        kr_valid_i = 1'b1;
        for (int c = 0; c < 12; c++) begin
            m_ready_i = (c % 2 == 1);
            step();
            pulses += int'(out_pulse_o);
            if (done_o === 1'b1) begin
                dones++;
                total_cnt++; if (pulses != 3) $display("[TB] FAIL toggle_done_timing: got pulses=%0d expected 3", pulses); else pass_cnt++;
            end
        end
        kr_valid_i = 1'b0;
        m_ready_i  = 1'b0;
        total_cnt++; if (pulses != 3) $display("[TB] FAIL toggle_pulses: got %0d expected 3", pulses); else pass_cnt++;
        total_cnt++; if (dones != 1) $display("[TB] FAIL toggle_done_count: got %0d expected 1", dones); else pass_cnt++;
        step();
    endtask

    task automatic test_gate();
        int accepted;
        accepted  = 0;
        max_in_i  = {16'd1, 16'd2};
        max_out_i = 16'd1;
        start_i   = 1'b1;
        step();
        start_i   = 1'b0;
        k_ready_i = 2'b11;
        s_valid_i = 2'b01;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (s_ready_o[0] === 1'b1) accepted++;
            step();
        end
        s_valid_i = '0;
        #1;
        total_cnt++; if (accepted != EXP_ACCEPTED) $display("[TB] FAIL gate_accepted: got %0d expected %0d", accepted, EXP_ACCEPTED); else pass_cnt++;
        total_cnt++; if (s_ready_o[0] !== EXP_SREADY_AFTER) $display("[TB] FAIL gate_sready_after: got %0b expected %0b", s_ready_o[0], EXP_SREADY_AFTER); else pass_cnt++;
        total_cnt++; if (in_done_o !== 2'b01) $display("[TB] FAIL gate_in_done: got %0b expected 01", in_done_o); else pass_cnt++;
        kr_valid_i = 1'b1;
        m_ready_i  = 1'b1;
        step();
        kr_valid_i = 1'b0;
        m_ready_i  = 1'b0;
        k_ready_i  = '0;
        total_cnt++; if (done_o !== 1'b1) $display("[TB] FAIL gate_done: got %0b expected 1", done_o); else pass_cnt++;
        step();
    endtask

    task automatic test_zero_len_restart();
        max_in_i  = {16'd1, 16'd1};
        max_out_i = 16'd0;
        start_i   = 1'b1;
        step();
        total_cnt++; if (done_o !== 1'b1 || idle_o !== 1'b0) $display("[TB] FAIL zero_done: got done=%0b idle=%0b expected 1/0", done_o, idle_o); else pass_cnt++;
        max_out_i = 16'd2;
        step();
        start_i = 1'b0;
        total_cnt++; if (idle_o !== 1'b0 || done_o !== 1'b0) $display("[TB] FAIL restart_run: got idle=%0b done=%0b expected 0/0", idle_o, done_o); else pass_cnt++;
        total_cnt++; if (in_done_o !== 2'b00) $display("[TB] FAIL restart_in_cleared: got %0b expected 00", in_done_o); else pass_cnt++;
        kr_valid_i = 1'b1;
        m_ready_i  = 1'b1;
        step();
        total_cnt++; if (done_o !== 1'b0) $display("[TB] FAIL restart_done_early: got %0b expected 0", done_o); else pass_cnt++;
        step();
        kr_valid_i = 1'b0;
        m_ready_i  = 1'b0;
        total_cnt++; if (done_o !== 1'b1) $display("[TB] FAIL restart_done: got %0b expected 1", done_o); else pass_cnt++;
        step();
        total_cnt++; if (idle_o !== 1'b1) $display("[TB] FAIL restart_idle: got %0b expected 1", idle_o); else pass_cnt++;
    endtask

    task automatic test_clear();
        max_in_i  = {16'd2, 16'd1};
        max_out_i = 16'd2;
        start_i   = 1'b1;
        step();
        start_i   = 1'b0;
        s_valid_i = 2'b01;
        k_ready_i = 2'b11;
        step();
        s_valid_i = '0;
        total_cnt++; if (in_done_o !== 2'b01) $display("[TB] FAIL clear_pre_in_done: got %0b expected 01", in_done_o); else pass_cnt++;
        kr_valid_i = 1'b1;
        m_ready_i  = 1'b1;
        step();
        kr_valid_i = 1'b0;
        m_ready_i  = 1'b0;
        clear_i    = 1'b1;
        start_i    = 1'b1;
        step();
        clear_i = 1'b0;
        start_i = 1'b0;
        total_cnt++; if (idle_o !== 1'b1 || done_o !== 1'b0) $display("[TB] FAIL clear_idle: got idle=%0b done=%0b expected 1/0", idle_o, done_o); else pass_cnt++;
        total_cnt++; if (in_done_o !== 2'b00) $display("[TB] FAIL clear_in_done: got %0b expected 00", in_done_o); else pass_cnt++;
        step();
        total_cnt++; if (idle_o !== 1'b1 || done_o !== 1'b0) $display("[TB] FAIL clear_stays_idle: got idle=%0b done=%0b expected 1/0", idle_o, done_o); else pass_cnt++;
        max_in_i  = {16'd2, 16'd2};
        max_out_i = 16'd2;
        start_i   = 1'b1;
        step();
        start_i   = 1'b0;
        s_valid_i = 2'b11;
        step();
        total_cnt++; if (in_done_o !== 2'b00) $display("[TB] FAIL clear_next_one_token: got %0b expected 00", in_done_o); else pass_cnt++;
        step();
        s_valid_i = '0;
        k_ready_i = '0;
        total_cnt++; if (in_done_o !== 2'b11) $display("[TB] FAIL clear_next_in_done: got %0b expected 11", in_done_o); else pass_cnt++;
        kr_valid_i = 1'b1;
        m_ready_i  = 1'b1;
        step();
        total_cnt++; if (done_o !== 1'b0) $display("[TB] FAIL clear_next_done_early: got %0b expected 0", done_o); else pass_cnt++;
        step();
        kr_valid_i = 1'b0;
        m_ready_i  = 1'b0;
        total_cnt++; if (done_o !== 1'b1) $display("[TB] FAIL clear_next_done: got %0b expected 1", done_o); else pass_cnt++;
        step();
    endtask

    task automatic test_async_reset();
        max_in_i  = {16'd2, 16'd1};
        max_out_i = 16'd2;
        start_i   = 1'b1;
        step();
        start_i    = 1'b0;
        s_valid_i  = 2'b01;
        k_ready_i  = 2'b11;
        kr_valid_i = 1'b1;
        m_ready_i  = 1'b1;
        step();
        idle_inputs();
        total_cnt++; if (in_done_o !== 2'b01 || out_pulse_o !== 1'b1) $display("[TB] FAIL areset_pre: got in_done=%0b pulse=%0b expected 01/1", in_done_o, out_pulse_o); else pass_cnt++;
        #2;
        rst_ni = 1'b0;
        #1;
        total_cnt++; if (idle_o !== 1'b1 || done_o !== 1'b0 || ready_o !== 1'b0) $display("[TB] FAIL areset_flags: got idle=%0b done=%0b ready=%0b expected 1/0/0", idle_o, done_o, ready_o); else pass_cnt++;
        total_cnt++; if (in_done_o !== 2'b00 || out_pulse_o !== 1'b0) $display("[TB] FAIL areset_outs: got in_done=%0b pulse=%0b expected 00/0", in_done_o, out_pulse_o); else pass_cnt++;
        step();
        rst_ni = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_basic_job();
        test_out_toggle();
        test_gate();
        test_zero_len_restart();
        test_clear();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
